// File: rtl/modred_pkg.sv
// Shared constants, bundles and helpers for the modred arbiter slice.
// Build macro MODRED_ARB_PRIO0_EN: requester 0 gets strict priority.
package modred_pkg;

  localparam int MODRED_LAT   = 5;
  localparam int MODRED_IN_W  = 510;
  localparam int MODRED_OUT_W = 255;
  localparam int SRC_MAX_W    = 3;
  localparam int TAG_MAX_W    = 8;

  localparam logic [255:0] P_CONST =
    (256'd5 << 248) - 256'd1;
  localparam logic [255:0] MU_CONST =
    (256'd1 << 250) + (256'd1 << 248) + 256'd1;

  typedef struct packed {
    logic                 valid;
    logic [SRC_MAX_W-1:0] src;
    logic [TAG_MAX_W-1:0] tag;
  } inflight_t;

  typedef struct packed {
    logic [SRC_MAX_W-1:0]    src;
    logic [TAG_MAX_W-1:0]    tag;
    logic [MODRED_OUT_W-1:0] data;
  } rsp_entry_t;

  // Index `off` steps after `base` inside the window [lo, lo+n).
  function automatic int rr_pick(
    input int base,
    input int off,
    input int lo,
    input int n
  );
    return lo + ((base - lo + off) % n);
  endfunction

endpackage

// File: rtl/modred_arbiter_if.sv
// Requester/consumer bundle of the modred arbiter.
// Build macro MODRED_ARB_PRIO0_EN does not change this interface.
interface modred_arbiter_if
  import modred_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int TAG_W   = 4
);
  localparam int SRC_W = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]             req_valid;
  logic [NUM_REQ*MODRED_IN_W-1:0] req_data;
  logic [NUM_REQ*TAG_W-1:0]       req_tag;
  logic [NUM_REQ-1:0]             req_ready;
  logic                           rsp_valid;
  logic                           rsp_ready;
  logic [MODRED_OUT_W-1:0]        rsp_data;
  logic [SRC_W-1:0]               rsp_src;
  logic [TAG_W-1:0]               rsp_tag;
  logic                           busy;

  modport master (
    output req_valid, req_data, req_tag,
    output rsp_ready,
    input  req_ready, rsp_valid, rsp_data,
    input  rsp_src, rsp_tag, busy
  );

  modport slave (
    input  req_valid, req_data, req_tag,
    input  rsp_ready,
    output req_ready, rsp_valid, rsp_data,
    output rsp_src, rsp_tag, busy
  );

endinterface

// File: rtl/modred.sv
// Five-stage Montgomery reduction for p = 5*2^248-1, R = 2^256.
// Build macro MODRED_ARB_PRIO0_EN does not affect this block.
module modred
  import modred_pkg::*;
(
  input  logic                    clk_i,
  input  logic [MODRED_IN_W-1:0]  a_i,
  output logic [MODRED_OUT_W-1:0] d_o
);

  logic [MODRED_IN_W-1:0]  a1_q;
  logic [MODRED_IN_W-1:0]  a2_q;
  logic [255:0]            m_d;
  logic [255:0]            m2_q;
  logic [MODRED_IN_W:0]    pm;
  logic [MODRED_IN_W:0]    sum;
  logic [MODRED_OUT_W-1:0] d3_q;
  logic [MODRED_OUT_W-1:0] d4_q;
  logic [MODRED_OUT_W-1:0] d5_q;

  // Both products are by constants and reduce to shift/add trees.
  always_comb begin
    m_d = a1_q[255:0] * MU_CONST;
    pm  = {255'b0, m2_q} * {255'b0, P_CONST};
    sum = {1'b0, a2_q} + pm;
  end

  // Datapath carries no reset; validity lives in the caller.
  always_ff @(posedge clk_i) begin
    a1_q <= a_i;
    a2_q <= a1_q;
    m2_q <= m_d;
    d3_q <= sum[MODRED_IN_W:256];
    d4_q <= d3_q;
    d5_q <= d4_q;
    assert (sum[255:0] == '0);
  end

  assign d_o = d5_q;

endmodule

// File: rtl/modred_rsp_fifo.sv
// Synchronous response FIFO with wrap-bit pointers and occupancy count.
// Build macro MODRED_ARB_PRIO0_EN does not affect this block.
module modred_rsp_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       wr_en_i,
  input  logic [WIDTH-1:0]           wr_data_i,
  input  logic                       rd_en_i,
  output logic [WIDTH-1:0]           rd_data_o,
  output logic                       empty_o,
  output logic                       full_o,
  output logic [$clog2(DEPTH):0]     count_o
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_q;
  logic [AW:0]      wr_d;
  logic [AW:0]      rd_q;
  logic [AW:0]      rd_d;

  assign count_o   = wr_q - rd_q;
  assign empty_o   = (count_o == '0);
  assign full_o    = (count_o == (AW+1)'(DEPTH));
  assign rd_data_o = mem_q[rd_q[AW-1:0]];

  always_comb begin
    wr_d = wr_q + (AW+1)'(wr_en_i);
    rd_d = rd_q + (AW+1)'(rd_en_i);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (wr_en_i) begin
      mem_q[wr_q[AW-1:0]] <= wr_data_i;
    end
  end

  // Credit at issue time makes a write into a full FIFO impossible.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      assert (!(wr_en_i && full_o && !rd_en_i));
      assert (!(rd_en_i && empty_o));
    end
  end

endmodule

// File: rtl/modred_arbiter.sv
// Shares one modred pipeline among NUM_REQ requesters with tag tracking.
// Build macro MODRED_ARB_PRIO0_EN: requester 0 has strict priority.
module modred_arbiter
  import modred_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int TAG_W      = 4,
  parameter int FIFO_DEPTH = 8
) (
  input  logic            clk,
  input  logic            rst,
  modred_arbiter_if.slave bus
);

  localparam int SRC_W = $clog2(NUM_REQ);
  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam int LAT_W = $clog2(MODRED_LAT + 1);

`ifdef MODRED_ARB_PRIO0_EN
  localparam logic [SRC_W-1:0] RR_RST = SRC_W'(1);
`else
  localparam logic [SRC_W-1:0] RR_RST = '0;
`endif

  logic [SRC_W-1:0]        rr_q;
  logic [SRC_W-1:0]        rr_d;
  logic [SRC_W-1:0]        gnt_idx;
  logic                    gnt_vld;
  logic                    credit;
  inflight_t               sr_q [MODRED_LAT];
  inflight_t               push;
  inflight_t               tail;
  logic [LAT_W-1:0]        infl_q;
  logic [LAT_W-1:0]        infl_d;
  logic [CNT_W-1:0]        fifo_cnt;
  logic                    fifo_empty;
  logic                    fifo_full;
  logic                    fifo_rd;
  rsp_entry_t              fifo_wdata;
  rsp_entry_t              fifo_rdata;
  logic [MODRED_IN_W-1:0]  mr_a;
  logic [MODRED_OUT_W-1:0] mr_d;

  assign tail   = sr_q[MODRED_LAT-1];
  assign credit = ({1'b0, fifo_cnt} + (CNT_W+1)'(infl_q))
                  < (CNT_W+1)'(FIFO_DEPTH);

  // Search downward so the closest match to rr_q is the last write.
  always_comb begin
    gnt_vld = 1'b0;
    gnt_idx = '0;
`ifdef MODRED_ARB_PRIO0_EN
    for (int k = NUM_REQ - 2; k >= 0; k--) begin
      if (bus.req_valid[rr_pick(int'(rr_q), k, 1, NUM_REQ - 1)]) begin
        gnt_vld = 1'b1;
        gnt_idx = SRC_W'(rr_pick(int'(rr_q), k, 1, NUM_REQ - 1));
      end
    end
    if (bus.req_valid[0]) begin
      gnt_vld = 1'b1;
      gnt_idx = '0;
    end
`else
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (bus.req_valid[rr_pick(int'(rr_q), k, 0, NUM_REQ)]) begin
        gnt_vld = 1'b1;
        gnt_idx = SRC_W'(rr_pick(int'(rr_q), k, 0, NUM_REQ));
      end
    end
`endif
    gnt_vld = gnt_vld & credit & ~rst;
  end

  always_comb begin
    rr_d = rr_q;
    if (gnt_vld) begin
`ifdef MODRED_ARB_PRIO0_EN
      if (gnt_idx != '0) begin
        rr_d = SRC_W'(rr_pick(int'(gnt_idx), 1, 1, NUM_REQ - 1));
      end
`else
      rr_d = SRC_W'(rr_pick(int'(gnt_idx), 1, 0, NUM_REQ));
`endif
    end
  end

  always_comb begin
    push = '0;
    mr_a = '0;
    if (gnt_vld) begin
      push.valid = 1'b1;
      push.src   = SRC_MAX_W'(gnt_idx);
      push.tag   = TAG_MAX_W'(bus.req_tag[gnt_idx*TAG_W +: TAG_W]);
      mr_a       = bus.req_data[gnt_idx*MODRED_IN_W +: MODRED_IN_W];
    end
  end

  assign infl_d = infl_q + LAT_W'(push.valid) - LAT_W'(tail.valid);

  assign bus.req_ready = gnt_vld ? (NUM_REQ'(1) << gnt_idx) : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_q   <= RR_RST;
      infl_q <= '0;
      for (int i = 0; i < MODRED_LAT; i++) begin
        sr_q[i] <= '0;
      end
    end else begin
      rr_q    <= rr_d;
      infl_q  <= infl_d;
      sr_q[0] <= push;
      for (int i = 1; i < MODRED_LAT; i++) begin
        sr_q[i] <= sr_q[i-1];
      end
    end
  end

  modred u_modred (
    .clk_i (clk),
    .a_i   (mr_a),
    .d_o   (mr_d)
  );

  assign fifo_wdata = '{src: tail.src, tag: tail.tag, data: mr_d};
  assign fifo_rd    = ~fifo_empty & bus.rsp_ready;

  modred_rsp_fifo #(
    .WIDTH ($bits(rsp_entry_t)),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i     (clk),
    .rst_i     (rst),
    .wr_en_i   (tail.valid),
    .wr_data_i (fifo_wdata),
    .rd_en_i   (fifo_rd),
    .rd_data_o (fifo_rdata),
    .empty_o   (fifo_empty),
    .full_o    (fifo_full),
    .count_o   (fifo_cnt)
  );

  assign bus.rsp_valid = ~fifo_empty;
  assign bus.rsp_data  = fifo_rdata.data;
  assign bus.rsp_src   = fifo_rdata.src[SRC_W-1:0];
  assign bus.rsp_tag   = fifo_rdata.tag[TAG_W-1:0];
  assign bus.busy      = (infl_q != '0) | (fifo_cnt != '0);

  // Stored metadata must always fit the configured widths.
  always_ff @(posedge clk) begin
    if (!rst && bus.rsp_valid) begin
      assert (int'(fifo_rdata.src) < NUM_REQ);
      assert ((fifo_rdata.tag >> TAG_W) == '0);
      assert (!(fifo_full && fifo_cnt == '0));
    end
  end

endmodule

// File: tb/tb_modred_arbiter.sv
// Self-checking bench for modred_arbiter: spec-level model plus directed literals.
// Build macro MODRED_ARB_PRIO0_EN selects the priority-0 model and test.
module tb_modred_arbiter;

  localparam int N     = 4;
  localparam int TW    = 4;
  localparam int DEPTH = 8;
  localparam int LAT   = 5;
  localparam int IW    = 510;
  localparam int OW    = 255;

  localparam logic [1023:0] R1K  = 1024'd1 << 256;
  localparam logic [1023:0] P1K  = (1024'd5 << 248) - 1024'd1;
  localparam logic [1023:0] MU1K =
    (1024'd1 << 250) + (1024'd1 << 248) + 1024'd1;
  localparam logic [IW-1:0] P_IN  = IW'(P1K);
  localparam logic [IW-1:0] R_IN  = IW'(R1K);

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  modred_arbiter_if #(.NUM_REQ(N), .TAG_W(TW)) bus ();

  modred_arbiter #(
    .NUM_REQ    (N),
    .TAG_W      (TW),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    int            src;
    int            tag;
    logic [OW-1:0] data;
    int            edge_no;
  } exp_t;

  exp_t q[$];
  int   rr_m;
  int   edge_n = 0;
  bit   armed  = 1'b0;
  int   total  = 0;
  int   passed = 0;

  function automatic logic [OW-1:0] golden(input logic [IW-1:0] a);
    logic [1023:0] aa;
    logic [1023:0] m;
    logic [1023:0] t;
    aa = 1024'(a);
    m  = ((aa % R1K) * MU1K) % R1K;
    t  = (aa + m * P1K) >> 256;
    return t[OW-1:0];
  endfunction

  function automatic int model_grant(input logic [N-1:0] v, input int rr);
`ifdef MODRED_ARB_PRIO0_EN
    if (v[0]) return 0;
    for (int k = 0; k < N - 1; k++) begin
      if (v[1 + ((rr - 1 + k) % (N - 1))]) return 1 + ((rr - 1 + k) % (N - 1));
    end
`else
    for (int k = 0; k < N; k++) begin
      if (v[(rr + k) % N]) return (rr + k) % N;
    end
`endif
    return -1;
  endfunction

  function automatic int next_rr(input int g, input int rr);
`ifdef MODRED_ARB_PRIO0_EN
    return (g == 0) ? rr : 1 + (g % (N - 1));
`else
    return (g + 1) % N;
`endif
  endfunction

  task automatic chk(input string nm, input logic [255:0] act,
                     input logic [255:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
  endtask

  always @(posedge clk) edge_n <= edge_n + 1;

  // Spec-level model: outstanding queue, credit, RR pointer, latency.
  always @(negedge clk) begin
    int g;
    logic [N-1:0] exp_rdy;
    bit exp_rv;
    exp_t e;
    g = -1;
    exp_rdy = '0;
    if (!rst && q.size() < DEPTH) g = model_grant(bus.req_valid, rr_m);
    if (g >= 0) exp_rdy = N'(1) << g;
    exp_rv = (q.size() > 0) && (q[0].edge_no + LAT <= edge_n);
    if (armed) begin
      chk("req_ready", 256'(bus.req_ready), 256'(exp_rdy));
      chk("rsp_valid", 256'(bus.rsp_valid), 256'(exp_rv));
      chk("busy", 256'(bus.busy), 256'(q.size() != 0));
      if (exp_rv && bus.rsp_valid === 1'b1) begin
        chk("rsp_data", 256'(bus.rsp_data), 256'(q[0].data));
        chk("rsp_src", 256'(bus.rsp_src), 256'(q[0].src));
        chk("rsp_tag", 256'(bus.rsp_tag), 256'(q[0].tag));
      end
    end
    if (rst) begin
      q.delete();
`ifdef MODRED_ARB_PRIO0_EN
      rr_m = 1;
`else
      rr_m = 0;
`endif
      armed = 1'b1;
    end else if (armed) begin
      if (exp_rv && bus.rsp_ready) void'(q.pop_front());
      if (g >= 0) begin
        e.src     = g;
        e.tag     = int'(bus.req_tag[g*TW +: TW]);
        e.data    = golden(bus.req_data[g*IW +: IW]);
        e.edge_no = edge_n + 1;
        q.push_back(e);
        rr_m = next_rr(g, rr_m);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input bit v,
                         input logic [IW-1:0] d, input logic [TW-1:0] t);
    bus.req_valid[i]        = v;
    bus.req_data[i*IW +: IW] = d;
    bus.req_tag[i*TW +: TW]  = t;
  endtask

  task automatic set_all(input bit v);
    for (int i = 0; i < N; i++) begin
      set_req(i, v, (IW'(i + 1) << 400) | IW'(32'hDEAD_0000 + i * 7),
              TW'(i + 8));
    end
  endtask

  task automatic wait_rsp(input int max, output int n);
    n = -1;
    for (int k = 1; k <= max; k++) begin
      @(negedge clk);
      if (bus.rsp_valid === 1'b1) begin
        n = k;
        break;
      end
    end
  endtask

  task automatic drain();
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (bus.busy === 1'b0) break;
    end
    chk("drain_busy", 256'(bus.busy), 256'(0));
  endtask

  task automatic do_reset(input int cyc);
    rst = 1'b1;
    repeat (cyc) tick();
    rst = 1'b0;
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int n;
    int ngr;
    bus.req_valid = '0;
    bus.req_data  = '0;
    bus.req_tag   = '0;
    bus.rsp_ready = 1'b1;
    do_reset(3);

    chk("gold_zero", 256'(golden('0)), 256'(0));
    chk("gold_p", 256'(golden(P_IN)), 256'(P1K));
    chk("gold_r", 256'(golden(R_IN)), 256'(1));

    // 1: single request, six-cycle turnaround
    set_req(0, 1'b1, '0, TW'(3));
    tick();
    set_req(0, 1'b0, '0, '0);
    wait_rsp(20, n);
    chk("t1_latency", 256'(n), 256'(6));
    chk("t1_data", 256'(bus.rsp_data), 256'(0));
    chk("t1_src", 256'(bus.rsp_src), 256'(0));
    chk("t1_tag", 256'(bus.rsp_tag), 256'(3));
    repeat (2) @(negedge clk);
    chk("t1_busy", 256'(bus.busy), 256'(0));

    // 2: back-to-back issue from requesters 1 and 2
    tick();
    set_req(1, 1'b1, P_IN, TW'(5));
    set_req(2, 1'b1, R_IN, TW'(6));
    tick();
    set_req(1, 1'b0, '0, '0);
    tick();
    set_req(2, 1'b0, '0, '0);
    wait_rsp(20, n);
    chk("t2_latency", 256'(n), 256'(5));
    chk("t2_data_p", 256'(bus.rsp_data), 256'(P1K));
    chk("t2_src_a", 256'(bus.rsp_src), 256'(1));
    chk("t2_tag_a", 256'(bus.rsp_tag), 256'(5));
    @(negedge clk);
    chk("t2_valid_b", 256'(bus.rsp_valid), 256'(1));
    chk("t2_data_1", 256'(bus.rsp_data), 256'(1));
    chk("t2_src_b", 256'(bus.rsp_src), 256'(2));
    chk("t2_tag_b", 256'(bus.rsp_tag), 256'(6));

    // 3: all valid, full-rate round robin
    tick();
    do_reset(2);
    set_all(1'b1);
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      chk("t3_grant", 256'(bus.req_ready), 256'(N'(1) << (c % N)));
      if (c >= 6) chk("t3_stream", 256'(bus.rsp_valid), 256'(1));
    end
    tick();
    set_all(1'b0);
    drain();

    // 4: backpressure fills exactly DEPTH credits
    tick();
    bus.rsp_ready = 1'b0;
    set_all(1'b1);
    ngr = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (bus.req_ready != '0) ngr++;
    end
    chk("t4_grants", 256'(ngr), 256'(DEPTH));
    chk("t4_stall", 256'(bus.req_ready), 256'(0));
    tick();
    bus.rsp_ready = 1'b1;
    n = -1;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      if (bus.req_ready != '0) begin
        n = k;
        break;
      end
    end
    chk("t4_resume", 256'(n), 256'(2));
    for (int c = 0; c < 16; c++) begin
      tick();
      bus.rsp_ready = c[0];
    end
    tick();
    bus.rsp_ready = 1'b1;
    set_all(1'b0);
    drain();

    // 5: reset with results still in flight
    tick();
    set_all(1'b1);
    repeat (3) tick();
    set_all(1'b0);
    repeat (2) tick();
    do_reset(1);
    ngr = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (bus.rsp_valid !== 1'b0) ngr++;
    end
    chk("t5_no_stale", 256'(ngr), 256'(0));
    chk("t5_busy", 256'(bus.busy), 256'(0));

`ifdef MODRED_ARB_PRIO0_EN
    // 6: requester 0 starves requester 2 while valid
    tick();
    set_req(0, 1'b1, IW'(77), TW'(1));
    set_req(2, 1'b1, IW'(99), TW'(2));
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      chk("t6_prio", 256'(bus.req_ready), 256'(4'b0001));
    end
    tick();
    set_req(0, 1'b0, '0, '0);
    @(negedge clk);
    chk("t6_other", 256'(bus.req_ready), 256'(4'b0100));
    tick();
    set_req(2, 1'b0, '0, '0);
    drain();
`endif

    repeat (2) @(negedge clk);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
